// File: rtl/xsim_dma_burst_reader.sv
// xsim_dma_burst_reader
//   Turns one burst request (handle, word-aligned byte address, length in
//   words, 0 meaning 256) into a stream of single-word DMA read requests, and
//   buffers the returned words in a small FIFO for the consumer.
//   A read is only issued when the FIFO is sure to have room for its
//   response. Every read already in flight and every word already buffered
//   counts against FIFO_DEPTH, so the DMA response path never needs
//   backpressure.
//
// Ports
//   CLK, RST_N                 clock; synchronous active-low reset
//   en_req / rdy_req           burst request handshake (req_handle, req_addr, req_len)
//   dma_*_readrequest          one 32-bit read per handshake (addr, handle)
//   dma_*_readresponse         response word handshake (dma_readresponse_data)
//   rdy_data / en_data         beat handshake (data_first, data_last)
//   busy                       burst in progress
module xsim_dma_burst_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        en_req,
    output logic        rdy_req,
    input  logic [31:0] req_handle,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        dma_rdy_readrequest,
    output logic        dma_en_readrequest,
    output logic [31:0] dma_readrequest_addr,
    output logic [31:0] dma_readrequest_handle,
    input  logic        dma_rdy_readresponse,
    output logic        dma_en_readresponse,
    input  logic [31:0] dma_readresponse_data,
    output logic        rdy_data,
    input  logic        en_data,
    output logic [31:0] data_first,
    output logic        data_last,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] handle;
        logic [31:0] base;
        logic [8:0]  len;     // 1..256
    } burst_t;

    state_t state, state_nxt;
    burst_t burst_q;

    logic [8:0]       issued_q, received_q, delivered_q;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic       accept, rsp_fire, pop;
    logic [8:0] outstanding;
    logic [9:0] credit_used;

    // Misaligned start addresses are simply never accepted.
    assign accept      = (state == IDLE) && en_req && (req_addr[1:0] == 2'b00);
    assign outstanding = issued_q - received_q;
    assign credit_used = {1'b0, outstanding} + 10'(fifo_count);
    assign rsp_fire    = dma_en_readresponse;
    assign pop         = en_data && rdy_data;

    // Address wraps naturally modulo 2^32.
    assign dma_readrequest_addr   = burst_q.base + {21'b0, issued_q, 2'b00};
    assign dma_readrequest_handle = burst_q.handle;

    assign rdy_data   = (fifo_count != '0);
    assign data_first = rdy_data ? fifo_mem[rd_ptr] : 32'h0;
    assign data_last  = rdy_data && (delivered_q == burst_q.len - 9'd1);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (dma_en_readrequest && (issued_q == burst_q.len - 9'd1)) state_nxt = DRAIN;
            DRAIN:   if (pop && data_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        rdy_req             = 1'b0;
        busy                = 1'b1;
        dma_en_readrequest  = 1'b0;
        dma_en_readresponse = 1'b0;
        case (state)
            IDLE: begin
                rdy_req = 1'b1;
                busy    = 1'b0;
            end
            ISSUE: begin
                dma_en_readrequest  = dma_rdy_readrequest && (issued_q < burst_q.len)
                                      && (credit_used < 10'(FIFO_DEPTH));
                dma_en_readresponse = dma_rdy_readresponse;
            end
            DRAIN:   dma_en_readresponse = dma_rdy_readresponse;
            default: ;
        endcase
    end

    // Burst bookkeeping and FIFO control.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            burst_q     <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            delivered_q <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (accept) begin
                burst_q.handle <= req_handle;
                burst_q.base   <= req_addr;
                burst_q.len    <= {(req_len == 8'd0), req_len};
                issued_q       <= '0;
                received_q     <= '0;
                delivered_q    <= '0;
            end else begin
                if (dma_en_readrequest) issued_q    <= issued_q + 9'd1;
                if (rsp_fire)           received_q  <= received_q + 9'd1;
                if (pop)                delivered_q <= delivered_q + 9'd1;
            end
            if (rsp_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({rsp_fire, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage needs no reset; data_first is masked while empty.
    always_ff @(posedge CLK) begin
        if (rsp_fire) fifo_mem[wr_ptr] <= dma_readresponse_data;
    end

endmodule

// File: tb/tb_xsim_dma_burst_reader.sv
// Bench for xsim_dma_burst_reader: a DMA engine model returning words from a
// synthetic memory, a randomized consumer, and a burst-level scoreboard.
module tb_xsim_dma_burst_reader;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        en_req = 1'b0;
    logic        rdy_req;
    logic [31:0] req_handle = '0;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        dma_rdy_readrequest = 1'b0;
    logic        dma_en_readrequest;
    logic [31:0] dma_readrequest_addr;
    logic [31:0] dma_readrequest_handle;
    logic        dma_rdy_readresponse = 1'b0;
    logic        dma_en_readresponse;
    logic [31:0] dma_readresponse_data = '0;
    logic        rdy_data;
    logic        en_data = 1'b0;
    logic [31:0] data_first;
    logic        data_last;
    logic        busy;

    xsim_dma_burst_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .en_req(en_req), .rdy_req(rdy_req),
        .req_handle(req_handle), .req_addr(req_addr), .req_len(req_len),
        .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
        .dma_readrequest_addr(dma_readrequest_addr), .dma_readrequest_handle(dma_readrequest_handle),
        .dma_rdy_readresponse(dma_rdy_readresponse), .dma_en_readresponse(dma_en_readresponse),
        .dma_readresponse_data(dma_readresponse_data),
        .rdy_data(rdy_data), .en_data(en_data),
        .data_first(data_first), .data_last(data_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard state for the burst in progress.
    bit          active, fast, seq_ok, cons_hold, done_pend, spurious, first_seen;
    logic [31:0] b_handle, b_addr, salt;
    int          b_len, n_req, n_rsp, n_beat, occ, cyc, acc_cyc;
    logic [31:0] rsp_q[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFEF00D;
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, then check just before the next posedge.
    task automatic step(input bit do_req);
        @(negedge CLK);
        en_req = do_req;
        if (!do_req && active && ($urandom_range(0, 7) == 0)) begin
            en_req     = 1'b1;              // must be ignored while busy
            req_handle = $urandom;
            req_addr   = $urandom;
            req_len    = 8'($urandom);
        end
        dma_rdy_readrequest = fast || ($urandom_range(0, 3) != 0);
        if (rsp_q.size() > 0 && (fast || $urandom_range(0, 2) != 0)) begin
            dma_rdy_readresponse  = 1'b1;
            dma_readresponse_data = mem_f(rsp_q[0]);
        end else begin
            dma_rdy_readresponse  = spurious;
            dma_readresponse_data = $urandom;
        end
        en_data = !cons_hold && (fast || $urandom_range(0, 2) != 0);
        #3;
        cyc++;
        if (done_pend) begin
            chk("rdy_req_after_last", rdy_req, 1);
            done_pend = 0;
        end
        chk("busy", busy, active);
        chk("rdy_req", rdy_req, !active);
        chk("rsp_en", dma_en_readresponse, dma_rdy_readresponse && active);
        if (dma_en_readrequest) begin
            chk("rd_expected", active && (n_req < b_len), 1);
            chk("rd_rdy", dma_rdy_readrequest, 1);
            chk("rd_handle", dma_readrequest_handle, b_handle);
            chk("rd_addr", dma_readrequest_addr, b_addr + 32'(4 * n_req));
            if (seq_ok) chk("rd_cycle", cyc, acc_cyc + 1 + n_req);
            rsp_q.push_back(dma_readrequest_addr);
            n_req++;
        end
        chk("rdy_data", rdy_data, active && (occ > 0));
        if (rdy_data) begin
            chk("data", data_first, mem_f(b_addr + 32'(4 * n_beat)));
            chk("data_last", data_last, n_beat == b_len - 1);
            if (seq_ok && !first_seen) chk("first_beat_cycle", cyc, acc_cyc + 3);
            first_seen = 1;
        end else begin
            chk("last_idle", data_last, 0);
        end
        if (rdy_data && en_data && active) begin
            n_beat++;
            occ--;
            if (n_beat == b_len) begin
                active    = 0;
                done_pend = 1;
            end
        end
        if (dma_en_readresponse && rsp_q.size() > 0) begin
            void'(rsp_q.pop_front());
            occ++;
            n_rsp++;
        end
        if (active) chk("credit", ((n_req - n_rsp) + occ) <= DEPTH, 1);
        if (do_req) begin
            chk("rdy_req_at_req", rdy_req, 1);
            if (req_addr[1:0] == 2'b00) begin
                active     = 1;
                b_handle   = req_handle;
                b_addr     = req_addr;
                b_len      = (req_len == 0) ? 256 : int'(req_len);
                n_req      = 0;
                n_rsp      = 0;
                n_beat     = 0;
                occ        = 0;
                first_seen = 0;
                acc_cyc    = cyc;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        en_req = 1'b1;
        req_addr = '0;
        dma_rdy_readrequest = 1'b1;
        dma_rdy_readresponse = 1'b1;
        en_data = 1'b1;
        rsp_q.delete();
        active = 0; occ = 0; n_req = 0; n_rsp = 0; n_beat = 0;
        done_pend = 0; cons_hold = 0;
        @(negedge CLK);
        #3;
        chk("rst_rdy_req", rdy_req, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", dma_en_readrequest, 0);
        chk("rst_rsp_en", dma_en_readresponse, 0);
        chk("rst_rdy_data", rdy_data, 0);
        chk("rst_data_last", data_last, 0);
        chk("rst_data_first", data_first, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        en_req = 1'b0;
        dma_rdy_readresponse = 1'b0;
        en_data = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] h, input logic [31:0] a, input logic [7:0] l,
                             input bit f, input int hold, input int abort_at);
        int budget;
        fast = f;
        seq_ok = f && (hold == 0);
        cons_hold = (hold > 0);
        req_handle = h;
        req_addr = a;
        req_len = l;
        step(1);
        budget = 0;
        while (active && budget < 4000) begin
            if (cons_hold && budget == hold) begin
                chk("stall_reads", n_req, (b_len < DEPTH) ? b_len : DEPTH);
                cons_hold = 0;
            end
            if (abort_at > 0 && n_beat == abort_at) break;
            step(0);
            budget++;
        end
        if (abort_at > 0 && active) begin
            do_reset();
        end else begin
            chk("burst_timeout", active, 0);
            if (active) do_reset();
            else        step(0);
        end
        fast = 0;
        seq_ok = 0;
        cons_hold = 0;
    endtask

    initial begin
        logic [31:0] ra;
        salt = $urandom;
        cyc = 0;
        do_reset();
        // single word, known memory content
        run_burst(32'd5, 32'h100, 8'd1, 1, 0, 0);
        // eight words from address 0, back-to-back
        run_burst($urandom, 32'h0, 8'd8, 1, 0, 0);
        // consumer stalled: reads stop at FIFO depth, then resume
        ra = $urandom; ra[1:0] = 2'b00;
        run_burst($urandom, ra, 8'd16, 1, 20, 0);
        // address wrap past 0xFFFFFFFC
        run_burst($urandom, 32'hFFFF_FFF8, 8'd4, 1, 0, 0);
        run_burst($urandom, 32'hFFFF_FFF8, 8'd4, 0, 0, 0);
        // misaligned request rejected; stray responses in IDLE not consumed
        spurious = 1;
        run_burst($urandom, 32'h102, 8'd4, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0);
        spurious = 0;
        // length 0 means 256 words
        ra = $urandom; ra[1:0] = 2'b00;
        run_burst($urandom, ra, 8'd0, 1, 0, 0);
        run_burst($urandom, 32'h0, 8'd0, 0, 0, 0);
        // reset after three beats, then a fresh short burst
        run_burst($urandom, 32'h0, 8'd8, 1, 0, 3);
        ra = $urandom; ra[1:0] = 2'b00;
        run_burst($urandom, ra, 8'd2, 0, 0, 0);
        // random bursts with random engine/consumer timing
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; ra[1:0] = 2'b00;
            run_burst($urandom, ra, 8'($urandom_range(1, 40)), bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 12 : 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
